// File: rtl/axis_packetizer.sv
// Frames a continuous AXI-Stream into packets of one header beat plus PKT_LEN payload beats.
// The output beat, tlast and tvalid are all registered; s_axis_tready is combinational from m_axis_tready.
module axis_packetizer #(
    parameter int AXIS_WIDTH = 32,
    parameter int PKT_LEN    = 8,
    parameter int SEQ_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  s_axis_tvalid,
    input  logic [AXIS_WIDTH-1:0] s_axis_tdata,
    output logic                  s_axis_tready,
    output logic                  m_axis_tvalid,
    output logic [AXIS_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic [SEQ_WIDTH-1:0]  pkt_count,
    output logic                  busy
);

    // Handshake: a beat moves on a rising edge where valid and ready are both high;
    // valid never drops and the beat never changes until that happens.

    typedef enum logic {IDLE, PAYLOAD} state_t;

    localparam logic [15:0] LEN      = 16'(PKT_LEN);
    localparam logic [15:0] LAST_IDX = 16'(PKT_LEN - 1);

    state_t                state, state_nxt;
    logic [15:0]           cnt, cnt_nxt;
    logic [SEQ_WIDTH-1:0]  seq, seq_nxt;
    logic                  valid_nxt, last_nxt;
    logic [AXIS_WIDTH-1:0] data_nxt, header;
    logic                  out_free, in_hs;

    assign out_free      = ~m_axis_tvalid | m_axis_tready;
    assign s_axis_tready = (state == PAYLOAD) & out_free;
    assign in_hs         = s_axis_tvalid & s_axis_tready;
    assign busy          = (state == PAYLOAD);
    assign pkt_count     = seq;

    always_comb begin
        header                   = '0;
        header[15:0]             = LEN;
        header[SEQ_WIDTH+15:16]  = seq;
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        seq_nxt   = seq;
        valid_nxt = m_axis_tvalid;
        data_nxt  = m_axis_tdata;
        last_nxt  = m_axis_tlast;
        case (state)
            IDLE: begin
                // The header is emitted without consuming the upstream beat that triggered it.
                if (s_axis_tvalid & out_free) begin
                    data_nxt  = header;
                    valid_nxt = 1'b1;
                    last_nxt  = 1'b0;
                    cnt_nxt   = '0;
                    state_nxt = PAYLOAD;
                end else if (out_free) begin
                    valid_nxt = 1'b0;
                end
            end
            PAYLOAD: begin
                if (in_hs) begin
                    data_nxt  = s_axis_tdata;
                    valid_nxt = 1'b1;
                    last_nxt  = (cnt == LAST_IDX);
                    cnt_nxt   = cnt + 16'd1;
                    if (cnt == LAST_IDX) begin
                        seq_nxt   = seq + SEQ_WIDTH'(1);
                        state_nxt = IDLE;
                    end
                end else if (out_free) begin
                    valid_nxt = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            cnt           <= '0;
            seq           <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            seq           <= seq_nxt;
            m_axis_tvalid <= valid_nxt;
            m_axis_tdata  <= data_nxt;
            m_axis_tlast  <= last_nxt;
        end
    end

endmodule
